instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_fetch.sv | 112 +++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction register-field positions
// and the program-counter increment.
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_BUSY  = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_t;

    localparam int REG_FIELD_W = 4;
    localparam int RN_LSB      = 16;
    localparam int RD_LSB      = 12;
    localparam int RS_LSB      = 8;
    localparam int RM_LSB      = 0;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a single-entry instruction register fed by a
// request/ack memory port, with branch redirect and discard of in-flight data.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        IR_valid,
    output logic [31:0] IR,
    output logic [3:0]  IR_addr_Rn,
    output logic [3:0]  IR_addr_Rd,
    output logic [3:0]  IR_addr_Rs,
    output logic [3:0]  IR_addr_Rm,
    output logic [31:0] PC_next,
    output logic [31:0] pc_r15
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_ir_q, pc_ir_d;
    logic [31:0]  ir_q, ir_d;
    logic         ir_valid_q, ir_valid_d;
    logic         imem_req_q, imem_req_d;
    logic         consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            pc_ir_q    <= RESET_PC;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_ir_q    <= pc_ir_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            imem_req_q <= imem_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_ir_d    = pc_ir_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        consume    = ir_valid_q && !stall && !branch_taken;

        if (consume) begin
            ir_valid_d = 1'b0;
        end

        // A new fetch is only issued when the IR slot is empty or being
        // consumed, so an accepted ack never overwrites a live instruction.
        case (state_q)
            FS_IDLE: begin
                if (!branch_taken && (!ir_valid_q || consume)) begin
                    state_d = FS_BUSY;
                end
            end
            FS_BUSY: begin
                if (branch_taken) begin
                    state_d = imem_ack ? FS_IDLE : FS_FLUSH;
                end else if (imem_ack) begin
                    ir_d       = imem_rdata;
                    pc_ir_d    = pc_q;
                    pc_d       = pc_q + PC_INC;
                    ir_valid_d = 1'b1;
                    state_d    = FS_IDLE;
                end
            end
            FS_FLUSH: begin
                if (imem_ack) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase

        // Redirect wins over stall and over any returning data.
        if (branch_taken) begin
            pc_d       = branch_target;
            ir_valid_d = 1'b0;
        end

        imem_req_d = (state_d != FS_IDLE);
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign IR_valid   = ir_valid_q;
    assign IR         = ir_q;
    assign IR_addr_Rn = ir_q[RN_LSB +: REG_FIELD_W];
    assign IR_addr_Rd = ir_q[RD_LSB +: REG_FIELD_W];
    assign IR_addr_Rs = ir_q[RS_LSB +: REG_FIELD_W];
    assign IR_addr_Rm = ir_q[RM_LSB +: REG_FIELD_W];
    assign PC_next    = pc_ir_q + PC_INC;
    assign pc_r15     = pc_ir_q + (PC_INC << 1);

endmodule
